id_ex_pipe: RTL and testbench
=============================

ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 The block SHALL provide parameter DATA_W, default 32, operand/PC datapath width.
REQ-003 The block SHALL provide parameter REG_AW, default 5, register-specifier width.
REQ-004 The block SHALL have port clk  input  1  rising-edge clock.
REQ-005 The block SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 The block SHALL have ports RegDst_i, Branch_i, MemRead_i, MemtoReg_i, MemWrite_i, ALUSrc_i, RegWrite_i  input  1 each  decoder control bits for the instruction in ID.
REQ-007 The block SHALL have port ALUOp_i  input  2  decoder ALU class (00 add, 01 sub/compare, 10 funct-decoded).
REQ-008 The block SHALL have ports pc4_i, rd1_i, rd2_i, imm_i  input  DATA_W each  ID-stage PC+4, register-file reads, sign-extended immediate.
REQ-009 The block SHALL have ports rs_i, rt_i, rd_i  input  REG_AW each  ID-stage register specifiers.
REQ-010 The block SHALL have port flush_i  input  1  taken-branch/jump squash of the ID instruction.
REQ-011 The block SHALL have port hold_i  input  1  external freeze (e.g. memory wait) of the whole front end.
REQ-012 The block SHALL have matching registered outputs *_o for every REQ-006..REQ-009 signal plus valid_o  output  1  EX holds a real instruction.
REQ-013 The block SHALL have port lu_stall_o  output  1  combinational load-use stall request to PC and IF/ID.

Function
REQ-014 lu_stall_o SHALL be 1 when valid_o=1, MemRead_o=1, rt_o!=0 and (rt_o==rs_i or rt_o==rt_i); else 0.
REQ-015 On each rising edge with rst=0, priority SHALL be: flush_i, then hold_i, then lu_stall_o, then normal load.
REQ-016 flush_i=1 SHALL load a bubble: valid_o=0 and all control outputs 0; data/specifier outputs don't-care.
REQ-017 hold_i=1 (flush_i=0) SHALL keep every output register unchanged; lu_stall_o stays evaluated combinationally.
REQ-018 lu_stall_o=1 (flush_i=0, hold_i=0) SHALL load a bubble as in REQ-016, so the stall lasts exactly one cycle.
REQ-019 Normal load SHALL capture all inputs in one cycle (latency 1) with valid_o=1.
REQ-020 A bubble SHALL never assert RegWrite_o, MemWrite_o, MemRead_o or Branch_o.
REQ-021 Specifier comparison SHALL be exact REG_AW-bit equality; register 0 SHALL never cause a stall.
REQ-022 lu_stall_o SHALL NOT depend on ID control inputs (conservative: stall even if ID ignores rt).

Reset
REQ-023 rst=1 SHALL, at the clock edge, clear valid_o and all control outputs to 0 and all data/specifier outputs to 0, overriding flush_i and hold_i.
REQ-024 Reset asserted mid-stall SHALL leave lu_stall_o=0 in the following cycle.

Structure
REQ-025 A shared package SHALL hold ALUOp encodings (ALU_ADD=00, ALU_SUB=01, ALU_FUNCT=10), the control-bundle struct/width (10 bits) and the bubble constant.
REQ-026 Load-use detection SHALL be a sub-module hazard_detect; the register is the top level.

Verification
REQ-027 lw (MemRead=1,rt=8) loaded, next ID rs=8 -> lu_stall_o=1, following edge valid_o=0, controls 0, then lu_stall_o=0.
REQ-028 lw rt=0 in EX, ID rs=0 -> lu_stall_o=0, normal load.
REQ-029 flush_i=1 together with lu_stall_o=1 and hold_i=1 -> bubble loaded (flush wins).
REQ-030 hold_i=1 for 3 cycles with add (RegDst=1,ALUOp=10,rd1=0x5,rd2=0x7) in EX -> outputs unchanged all 3 cycles.
REQ-031 rst=1 during lu_stall_o=1 -> next cycle all outputs 0, lu_stall_o=0.
REQ-032 Back-to-back sw, beq, R-type loads -> each appears on outputs exactly one cycle later, field for field.

Source files
------------

// File: rtl/id_ex_pipe_pkg.sv
// Shared definitions for the ID/EX pipeline register: ALU class codes, the
// registered control bundle and the bubble value loaded on flush or stall.
package id_ex_pipe_pkg;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef struct packed {
        logic       valid;
        logic       reg_dst;
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam int unsigned CTRL_W = $bits(ctrl_t);

    // All-zero bundle: no side effects can leak from a squashed slot.
    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_pipe_hazard_detect.sv
// Load-use hazard detector: a load in EX whose destination rt is read by the
// instruction in ID forces a one-cycle stall.
module hazard_detect #(
    parameter int unsigned REG_AW = 5
) (
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    output logic              stall
);

    logic rt_nonzero;
    logic rt_match;

    // ID control bits are deliberately ignored: stalling is conservative.
    always_comb begin
        rt_nonzero = (ex_rt != '0);
        rt_match   = (ex_rt == id_rs) || (ex_rt == id_rt);
        stall      = ex_valid && ex_mem_read && rt_nonzero && rt_match;
    end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with flush, hold and load-use bubble insertion.
// Priority on each edge: reset, flush, hold, load-use stall, normal load.
module id_ex_pipe
    import id_ex_pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegDst_i,
    input  logic              Branch_i,
    input  logic              MemRead_i,
    input  logic              MemtoReg_i,
    input  logic              MemWrite_i,
    input  logic              ALUSrc_i,
    input  logic              RegWrite_i,
    input  logic [1:0]        ALUOp_i,
    input  logic [DATA_W-1:0] pc4_i,
    input  logic [DATA_W-1:0] rd1_i,
    input  logic [DATA_W-1:0] rd2_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [REG_AW-1:0] rs_i,
    input  logic [REG_AW-1:0] rt_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic              flush_i,
    input  logic              hold_i,
    output logic              RegDst_o,
    output logic              Branch_o,
    output logic              MemRead_o,
    output logic              MemtoReg_o,
    output logic              MemWrite_o,
    output logic              ALUSrc_o,
    output logic              RegWrite_o,
    output logic [1:0]        ALUOp_o,
    output logic [DATA_W-1:0] pc4_o,
    output logic [DATA_W-1:0] rd1_o,
    output logic [DATA_W-1:0] rd2_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [REG_AW-1:0] rs_o,
    output logic [REG_AW-1:0] rt_o,
    output logic [REG_AW-1:0] rd_o,
    output logic              valid_o,
    output logic              lu_stall_o
);

    ctrl_t             ctrl_q, ctrl_d, id_ctrl;
    logic [DATA_W-1:0] pc4_q, pc4_d, rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
    logic [REG_AW-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic              lu_stall;

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard_detect (
        .ex_valid    (ctrl_q.valid),
        .ex_mem_read (ctrl_q.mem_read),
        .ex_rt       (rt_q),
        .id_rs       (rs_i),
        .id_rt       (rt_i),
        .stall       (lu_stall)
    );

    always_comb begin
        id_ctrl = '{
            valid:      1'b1,
            reg_dst:    RegDst_i,
            branch:     Branch_i,
            mem_read:   MemRead_i,
            mem_to_reg: MemtoReg_i,
            mem_write:  MemWrite_i,
            alu_src:    ALUSrc_i,
            reg_write:  RegWrite_i,
            alu_op:     ALUOp_i
        };
    end

    // Data fields only move on a real load; in a bubble they are don't-care.
    always_comb begin
        ctrl_d = ctrl_q;
        pc4_d  = pc4_q;
        rd1_d  = rd1_q;
        rd2_d  = rd2_q;
        imm_d  = imm_q;
        rs_d   = rs_q;
        rt_d   = rt_q;
        rd_d   = rd_q;
        if (flush_i) begin
            ctrl_d = CTRL_BUBBLE;
        end else if (hold_i) begin
            ctrl_d = ctrl_q;
        end else if (lu_stall) begin
            ctrl_d = CTRL_BUBBLE;
        end else begin
            ctrl_d = id_ctrl;
            pc4_d  = pc4_i;
            rd1_d  = rd1_i;
            rd2_d  = rd2_i;
            imm_d  = imm_i;
            rs_d   = rs_i;
            rt_d   = rt_i;
            rd_d   = rd_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q <= CTRL_BUBBLE;
            pc4_q  <= '0;
            rd1_q  <= '0;
            rd2_q  <= '0;
            imm_q  <= '0;
            rs_q   <= '0;
            rt_q   <= '0;
            rd_q   <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            pc4_q  <= pc4_d;
            rd1_q  <= rd1_d;
            rd2_q  <= rd2_d;
            imm_q  <= imm_d;
            rs_q   <= rs_d;
            rt_q   <= rt_d;
            rd_q   <= rd_d;
        end
    end

    always_comb begin
        valid_o    = ctrl_q.valid;
        RegDst_o   = ctrl_q.reg_dst;
        Branch_o   = ctrl_q.branch;
        MemRead_o  = ctrl_q.mem_read;
        MemtoReg_o = ctrl_q.mem_to_reg;
        MemWrite_o = ctrl_q.mem_write;
        ALUSrc_o   = ctrl_q.alu_src;
        RegWrite_o = ctrl_q.reg_write;
        ALUOp_o    = ctrl_q.alu_op;
        pc4_o      = pc4_q;
        rd1_o      = rd1_q;
        rd2_o      = rd2_q;
        imm_o      = imm_q;
        rs_o       = rs_q;
        rt_o       = rt_q;
        rd_o       = rd_q;
        lu_stall_o = lu_stall;
    end

endmodule

// File: tb/tb_id_ex_pipe.sv
// Scoreboard bench for id_ex_pipe: a behavioural model predicts the EX-stage
// contents and stall request; a negedge monitor pops and compares each cycle.
module tb_id_ex_pipe;

    typedef struct packed {
        logic        rst, flush, hold;
        logic        reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
        logic [1:0]  alu_op;
        logic [31:0] pc4, rd1, rd2, imm;
        logic [4:0]  rs, rt, rd;
    } stim_t;

    typedef struct packed {
        logic        valid, known;
        logic        reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
        logic [1:0]  alu_op;
        logic [31:0] pc4, rd1, rd2, imm;
        logic [4:0]  rs, rt, rd;
    } ex_t;

    typedef struct packed {
        logic check;
        logic stall;
        ex_t  o;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, flush_i, hold_i;
    logic        RegDst_i, Branch_i, MemRead_i, MemtoReg_i, MemWrite_i, ALUSrc_i, RegWrite_i;
    logic [1:0]  ALUOp_i;
    logic [31:0] pc4_i, rd1_i, rd2_i, imm_i;
    logic [4:0]  rs_i, rt_i, rd_i;
    logic        RegDst_o, Branch_o, MemRead_o, MemtoReg_o, MemWrite_o, ALUSrc_o, RegWrite_o;
    logic [1:0]  ALUOp_o;
    logic [31:0] pc4_o, rd1_o, rd2_o, imm_o;
    logic [4:0]  rs_o, rt_o, rd_o;
    logic        valid_o, lu_stall_o;

    exp_t q[$];
    int   n_pass = 0;
    int   n_total = 0;
    logic m_init = 1'b0;
    ex_t  m = '0;

    always #5 clk = ~clk;

    id_ex_pipe dut (
        .clk(clk), .rst(rst),
        .RegDst_i(RegDst_i), .Branch_i(Branch_i), .MemRead_i(MemRead_i),
        .MemtoReg_i(MemtoReg_i), .MemWrite_i(MemWrite_i), .ALUSrc_i(ALUSrc_i),
        .RegWrite_i(RegWrite_i), .ALUOp_i(ALUOp_i),
        .pc4_i(pc4_i), .rd1_i(rd1_i), .rd2_i(rd2_i), .imm_i(imm_i),
        .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i),
        .flush_i(flush_i), .hold_i(hold_i),
        .RegDst_o(RegDst_o), .Branch_o(Branch_o), .MemRead_o(MemRead_o),
        .MemtoReg_o(MemtoReg_o), .MemWrite_o(MemWrite_o), .ALUSrc_o(ALUSrc_o),
        .RegWrite_o(RegWrite_o), .ALUOp_o(ALUOp_o),
        .pc4_o(pc4_o), .rd1_o(rd1_o), .rd2_o(rd2_o), .imm_o(imm_o),
        .rs_o(rs_o), .rt_o(rt_o), .rd_o(rd_o),
        .valid_o(valid_o), .lu_stall_o(lu_stall_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    endtask

    function automatic logic [8:0] ctrl_of(input ex_t e);
        return {e.reg_dst, e.branch, e.mem_read, e.mem_to_reg, e.mem_write,
                e.alu_src, e.reg_write, e.alu_op};
    endfunction

    // Monitor: outputs settle after posedge, inputs after posedge+2.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.check) begin
                chk("lu_stall", {63'd0, lu_stall_o}, {63'd0, e.stall});
                chk("valid", {63'd0, valid_o}, {63'd0, e.o.valid});
                chk("ctrl", {55'd0, RegDst_o, Branch_o, MemRead_o, MemtoReg_o, MemWrite_o,
                             ALUSrc_o, RegWrite_o, ALUOp_o}, {55'd0, ctrl_of(e.o)});
                if (e.o.known) begin
                    chk("pc4", {32'd0, pc4_o}, {32'd0, e.o.pc4});
                    chk("rd1", {32'd0, rd1_o}, {32'd0, e.o.rd1});
                    chk("rd2", {32'd0, rd2_o}, {32'd0, e.o.rd2});
                    chk("imm", {32'd0, imm_o}, {32'd0, e.o.imm});
                    chk("rs", {59'd0, rs_o}, {59'd0, e.o.rs});
                    chk("rt", {59'd0, rt_o}, {59'd0, e.o.rt});
                    chk("rd", {59'd0, rd_o}, {59'd0, e.o.rd});
                end
            end
        end
    end

    // Drive one cycle of ID inputs, predict from the model, then advance it.
    task automatic apply(input stim_t s);
        exp_t e;
        ex_t  bub;
        logic stall;
        @(posedge clk);
        #2;
        rst = s.rst; flush_i = s.flush; hold_i = s.hold;
        RegDst_i = s.reg_dst; Branch_i = s.branch; MemRead_i = s.mem_read;
        MemtoReg_i = s.mem_to_reg; MemWrite_i = s.mem_write; ALUSrc_i = s.alu_src;
        RegWrite_i = s.reg_write; ALUOp_i = s.alu_op;
        pc4_i = s.pc4; rd1_i = s.rd1; rd2_i = s.rd2; imm_i = s.imm;
        rs_i = s.rs; rt_i = s.rt; rd_i = s.rd;
        stall = m.valid && m.mem_read && (m.rt != 0) && (m.rt == s.rs || m.rt == s.rt);
        e.check = m_init;
        e.stall = stall;
        e.o     = m;
        q.push_back(e);
        bub = '0;
        if (s.rst) begin
            m = '0;
            m.known = 1'b1;
            m_init = 1'b1;
        end else if (!m_init || s.hold && !s.flush) begin
            m = m;
        end else if (s.flush || stall) begin
            m = bub;
        end else begin
            m = '{valid: 1'b1, known: 1'b1, reg_dst: s.reg_dst, branch: s.branch,
                  mem_read: s.mem_read, mem_to_reg: s.mem_to_reg, mem_write: s.mem_write,
                  alu_src: s.alu_src, reg_write: s.reg_write, alu_op: s.alu_op,
                  pc4: s.pc4, rd1: s.rd1, rd2: s.rd2, imm: s.imm,
                  rs: s.rs, rt: s.rt, rd: s.rd};
        end
    endtask

    function automatic stim_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        stim_t s = '0;
        s.rs = rs; s.rt = rt; s.rd = rd;
        s.pc4 = $urandom; s.rd1 = $urandom; s.rd2 = $urandom; s.imm = $urandom;
        return s;
    endfunction

    function automatic stim_t lw(input logic [4:0] rs, input logic [4:0] rt);
        stim_t s = mk(rs, rt, 5'd0);
        s.mem_read = 1; s.mem_to_reg = 1; s.alu_src = 1; s.reg_write = 1; s.alu_op = 2'b00;
        return s;
    endfunction

    function automatic stim_t rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        stim_t s = mk(rs, rt, rd);
        s.reg_dst = 1; s.reg_write = 1; s.alu_op = 2'b10;
        return s;
    endfunction

    initial begin
        stim_t s, r;
        rst = 1; flush_i = 0; hold_i = 0;
        {RegDst_i, Branch_i, MemRead_i, MemtoReg_i, MemWrite_i, ALUSrc_i, RegWrite_i} = '0;
        ALUOp_i = 0; pc4_i = 0; rd1_i = 0; rd2_i = 0; imm_i = 0; rs_i = 0; rt_i = 0; rd_i = 0;

        s = mk(5'd3, 5'd4, 5'd5); s.rst = 1; s.flush = 1; s.hold = 1;
        apply(s);
        apply(s);
        // lw rt=8 then consumer rs=8: stall, bubble, then consumer loads
        apply(lw(5'd1, 5'd8));
        r = rtype(5'd8, 5'd2, 5'd9);
        apply(r); apply(r); apply(r);
        // lw to $0 never stalls
        apply(lw(5'd1, 5'd0));
        apply(rtype(5'd0, 5'd0, 5'd3));
        // flush beats hold and stall
        apply(lw(5'd2, 5'd9));
        s = rtype(5'd9, 5'd9, 5'd1); s.flush = 1; s.hold = 1;
        apply(s);
        apply(rtype(5'd1, 5'd2, 5'd3));
        // add held for three cycles
        s = rtype(5'd1, 5'd2, 5'd3); s.rd1 = 32'h5; s.rd2 = 32'h7;
        apply(s);
        for (int i = 0; i < 3; i++) begin
            r = rtype(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'd4);
            r.hold = 1;
            apply(r);
        end
        apply(rtype(5'd6, 5'd7, 5'd8));
        // reset during a load-use stall
        apply(lw(5'd1, 5'd4));
        s = rtype(5'd4, 5'd1, 5'd2); s.rst = 1;
        apply(s);
        apply(rtype(5'd4, 5'd4, 5'd2));
        // sw, beq, R-type back to back
        s = mk(5'd1, 5'd2, 5'd0); s.mem_write = 1; s.alu_src = 1; s.alu_op = 2'b00;
        apply(s);
        s = mk(5'd3, 5'd4, 5'd0); s.branch = 1; s.alu_op = 2'b01;
        apply(s);
        apply(rtype(5'd5, 5'd6, 5'd7));

        for (int i = 0; i < 2000; i++) begin
            s = mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
            {s.reg_dst, s.branch, s.mem_to_reg, s.mem_write, s.alu_src, s.reg_write} = 6'($urandom);
            s.mem_read = ($urandom_range(0, 99) < 40);
            s.alu_op   = 2'($urandom_range(0, 2));
            s.flush    = ($urandom_range(0, 99) < 8);
            s.hold     = ($urandom_range(0, 99) < 20);
            s.rst      = ($urandom_range(0, 99) < 2);
            apply(s);
        end

        repeat (3) @(negedge clk);
        n_total++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d entries left, expected 0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
